// File: rtl/led7seg_pkg.sv
// Shared definitions for the 7-segment display family: scan states,
// hex font table and segment bit positions on the LED bus.
package led7seg_pkg;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } state_t;

   // Segment bit positions on the LED bus (active-high).
   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   // Hex font, bit 6..0 = g..a. Index is the nibble value.
   localparam logic [6:0] FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/led7seg_font.sv
// Combinational nibble-to-segment decoder. The decimal point is passed
// through even when the digit glyph is blanked.
module led7seg_font
   import led7seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   input  logic       blank_i,
   output logic [7:0] led_o
);

   // Look up the glyph, optionally blank it, and attach the decimal point.
   always_comb begin
      led_o = 8'h00;
      if (blank_i) begin
         led_o[SEG_G:SEG_A] = 7'h00;
      end else begin
         led_o[SEG_G:SEG_A] = FONT[nibble_i];
      end
      led_o[SEG_DP] = dp_i;
   end

endmodule

// File: rtl/led7seg_scan.sv
// Four-digit multiplexed 7-segment driver. New values are captured into a
// shadow register and only copied to the displayed value at the end of a
// full frame, so a frame always shows one consistent value. Each digit slot
// starts with a short all-off gap to suppress ghosting between digits.
module led7seg_scan
   import led7seg_pkg::*;
#(
   parameter int DIV      = 50000,
   parameter int BLANK    = 16,
   parameter int LZ_BLANK = 0
)
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        LOAD,
   input  logic [15:0] DATA_IN,
   input  logic [3:0]  DP_IN,
   output logic [7:0]  LED,
   output logic [3:0]  SA,
   output logic        FRAME_UPD
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - BLANK - 1);

   state_t         state_q,  state_d;
   logic [CW-1:0]  cnt_q,    cnt_d;
   logic [1:0]     digit_q,  digit_d;
   logic [19:0]    active_q, active_d;   // {dp[3:0], hex[15:0]} on display
   logic [19:0]    shadow_q, shadow_d;   // last loaded, not yet applied
   logic           pend_q,   pend_d;
   logic [7:0]     led_q,    led_d;
   logic [3:0]     sa_q,     sa_d;
   logic           upd_q,    upd_d;

   logic           boundary_s;
   logic [3:0]     nibble_s;
   logic           dp_s;
   logic           lz_s;
   logic [7:0]     font_led_s;

   assign boundary_s = (state_q == S_SHOW) && (cnt_q == SHOW_LAST) && (digit_q == 2'd3);

   // Slot timing: blank gap, then show the digit, then advance to the next digit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      digit_d = digit_q;
      case (state_q)
         S_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = S_SHOW;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         S_SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               state_d = S_BLANK;
               cnt_d   = '0;
               digit_d = digit_q + 2'd1;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_BLANK;
            cnt_d   = '0;
            digit_d = 2'd0;
         end
      endcase
   end

   // Shadow capture and frame-boundary apply; a load on the boundary edge bypasses the shadow.
   always_comb begin
      active_d = active_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      upd_d    = 1'b0;
      if (boundary_s) begin
         if (LOAD) begin
            active_d = {DP_IN, DATA_IN};
            shadow_d = {DP_IN, DATA_IN};
            pend_d   = 1'b0;
            upd_d    = 1'b1;
         end else if (pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
            upd_d    = 1'b1;
         end else begin
            upd_d    = 1'b0;
         end
      end else begin
         if (LOAD) begin
            shadow_d = {DP_IN, DATA_IN};
            pend_d   = 1'b1;
         end else begin
            pend_d   = pend_q;
         end
      end
   end

   // Select the nibble, dp and leading-zero blank for the digit about to be shown.
   always_comb begin
      nibble_s = 4'h0;
      dp_s     = 1'b0;
      lz_s     = 1'b0;
      case (digit_d)
         2'd0: begin
            nibble_s = active_d[3:0];
            dp_s     = active_d[16];
            lz_s     = 1'b0;
         end
         2'd1: begin
            nibble_s = active_d[7:4];
            dp_s     = active_d[17];
            lz_s     = (active_d[15:4] == 12'h000);
         end
         2'd2: begin
            nibble_s = active_d[11:8];
            dp_s     = active_d[18];
            lz_s     = (active_d[15:8] == 8'h00);
         end
         2'd3: begin
            nibble_s = active_d[15:12];
            dp_s     = active_d[19];
            lz_s     = (active_d[15:12] == 4'h0);
         end
         default: begin
            nibble_s = 4'h0;
            dp_s     = 1'b0;
            lz_s     = 1'b0;
         end
      endcase
   end

   led7seg_font u_font (
      .nibble_i (nibble_s),
      .dp_i     (dp_s),
      .blank_i  (lz_s && (LZ_BLANK != 0)),
      .led_o    (font_led_s)
   );

   // Output pattern for the next cycle, so outputs move on the same edge as the state.
   always_comb begin
      sa_d  = 4'b0000;
      led_d = 8'h00;
      if (state_d == S_SHOW) begin
         sa_d  = 4'b0001 << digit_d;
         led_d = font_led_s;
      end else begin
         sa_d  = 4'b0000;
         led_d = 8'h00;
      end
   end

   // State, data and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= S_BLANK;
         cnt_q    <= '0;
         digit_q  <= 2'd0;
         active_q <= 20'h00000;
         shadow_q <= 20'h00000;
         pend_q   <= 1'b0;
         led_q    <= 8'h00;
         sa_q     <= 4'b0000;
         upd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         digit_q  <= digit_d;
         active_q <= active_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         led_q    <= led_d;
         sa_q     <= sa_d;
         upd_q    <= upd_d;
      end
   end

   assign LED       = led_q;
   assign SA        = sa_q;
   assign FRAME_UPD = upd_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// Directed bench for led7seg_scan with DIV=8, BLANK=2. Two instances share
// the inputs: dut0 without and dut1 with leading-zero suppression.
// Cycle 0 is the cycle right after the last reset edge.
module tb_led7seg_scan;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [7:0]  led0, led1;
   logic [3:0]  sa0, sa1;
   logic        fu0, fu1;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   led7seg_scan #(.DIV(8), .BLANK(2), .LZ_BLANK(0)) dut0 (
      .CLK(clk), .RST_N(rst_n), .LOAD(load), .DATA_IN(data_in), .DP_IN(dp_in),
      .LED(led0), .SA(sa0), .FRAME_UPD(fu0)
   );

   led7seg_scan #(.DIV(8), .BLANK(2), .LZ_BLANK(1)) dut1 (
      .CLK(clk), .RST_N(rst_n), .LOAD(load), .DATA_IN(data_in), .DP_IN(dp_in),
      .LED(led1), .SA(sa1), .FRAME_UPD(fu1)
   );

   function automatic logic [6:0] font7(input logic [3:0] n);
      case (n)
         4'h0: font7 = 7'h3F;  4'h1: font7 = 7'h06;  4'h2: font7 = 7'h5B;  4'h3: font7 = 7'h4F;
         4'h4: font7 = 7'h66;  4'h5: font7 = 7'h6D;  4'h6: font7 = 7'h7D;  4'h7: font7 = 7'h07;
         4'h8: font7 = 7'h7F;  4'h9: font7 = 7'h6F;  4'hA: font7 = 7'h77;  4'hB: font7 = 7'h7C;
         4'hC: font7 = 7'h39;  4'hD: font7 = 7'h5E;  4'hE: font7 = 7'h79;  4'hF: font7 = 7'h71;
         default: font7 = 7'h00;
      endcase
   endfunction

   // Expected {SA, LED} at cycle c with value v / dp shown.
   function automatic logic [11:0] exp_out(input logic [15:0] v, input logic [3:0] dp,
                                           input int c, input bit lz);
      int         pos;
      int         d;
      logic [6:0] seg;
      logic [15:0] hi;
      pos = c % 8;
      d   = (c / 8) % 4;
      if (pos < 2) return 12'h000;
      seg = font7(v[d*4 +: 4]);
      hi  = v >> (d * 4);
      if (lz && d != 0 && hi == 16'h0000) seg = 7'h00;
      return {4'b0001 << d, dp[d], seg};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      load  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      load  = 1'b0;
      tick();
      tick();
      n_tests++;
      if ({sa0, led0, fu0} !== 13'h0000) begin
         n_fail++;
         $display("FAIL reset dut0 got sa=%b led=%h fu=%b exp sa=0000 led=00 fu=0", sa0, led0, fu0);
      end
      n_tests++;
      if ({sa1, led1, fu1} !== 13'h0000) begin
         n_fail++;
         $display("FAIL reset dut1 got sa=%b led=%h fu=%b exp sa=0000 led=00 fu=0", sa1, led1, fu1);
      end
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_scan;
      logic [11:0] e;
      do_reset();
      while (cyc <= 39) begin
         e = exp_out(16'h0000, 4'h0, cyc, 1'b0);
         n_tests++;
         if ({sa0, led0} !== e || fu0 !== 1'b0) begin
            n_fail++;
            $display("FAIL scan c=%0d got sa=%b led=%h fu=%b exp sa=%b led=%h fu=0",
                     cyc, sa0, led0, fu0, e[11:8], e[7:0]);
         end
         tick();
      end
   endtask

   task automatic test_load;
      logic [11:0] e;
      do_reset();
      while (cyc <= 70) begin
         e = (cyc >= 32) ? exp_out(16'h12AF, 4'b0100, cyc, 1'b0) : exp_out(16'h0000, 4'h0, cyc, 1'b0);
         n_tests++;
         if ({sa0, led0} !== e || fu0 !== (cyc == 32)) begin
            n_fail++;
            $display("FAIL load c=%0d got sa=%b led=%h fu=%b exp sa=%b led=%h fu=%b",
                     cyc, sa0, led0, fu0, e[11:8], e[7:0], (cyc == 32));
         end
         if (cyc == 34 || cyc == 42 || cyc == 50 || cyc == 58) begin
            n_tests++;
            if (led0 !== ((cyc == 34) ? 8'h71 : (cyc == 42) ? 8'h77 : (cyc == 50) ? 8'hDB : 8'h06)) begin
               n_fail++;
               $display("FAIL load_glyph c=%0d got led=%h", cyc, led0);
            end
         end
         if (cyc == 5) begin
            load = 1'b1; data_in = 16'h12AF; dp_in = 4'b0100;
         end else begin
            load = 1'b0;
         end
         tick();
      end
      load = 1'b0;
   endtask

   task automatic test_two_loads;
      logic [11:0] e;
      int pulses;
      pulses = 0;
      do_reset();
      while (cyc <= 70) begin
         e = (cyc >= 32) ? exp_out(16'h2222, 4'h0, cyc, 1'b0) : exp_out(16'h0000, 4'h0, cyc, 1'b0);
         if (fu0 === 1'b1) pulses++;
         n_tests++;
         if ({sa0, led0} !== e || fu0 !== (cyc == 32)) begin
            n_fail++;
            $display("FAIL two_loads c=%0d got sa=%b led=%h fu=%b exp sa=%b led=%h fu=%b",
                     cyc, sa0, led0, fu0, e[11:8], e[7:0], (cyc == 32));
         end
         if (cyc == 3) begin
            load = 1'b1; data_in = 16'h1111; dp_in = 4'h0;
         end else if (cyc == 20) begin
            load = 1'b1; data_in = 16'h2222; dp_in = 4'h0;
         end else begin
            load = 1'b0;
         end
         tick();
      end
      n_tests++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL two_loads_pulses got %0d exp 1", pulses);
      end
   endtask

   task automatic test_boundary_load;
      logic [11:0] e;
      do_reset();
      while (cyc <= 70) begin
         e = (cyc >= 32) ? exp_out(16'h0005, 4'h0, cyc, 1'b0) : exp_out(16'h0000, 4'h0, cyc, 1'b0);
         n_tests++;
         if ({sa0, led0} !== e || fu0 !== (cyc == 32)) begin
            n_fail++;
            $display("FAIL boundary c=%0d got sa=%b led=%h fu=%b exp sa=%b led=%h fu=%b",
                     cyc, sa0, led0, fu0, e[11:8], e[7:0], (cyc == 32));
         end
         if (cyc == 34) begin
            n_tests++;
            if (led0 !== 8'h6D) begin
               n_fail++;
               $display("FAIL boundary_digit0 got led=%h exp 6d", led0);
            end
         end
         if (cyc == 31) begin
            load = 1'b1; data_in = 16'h0005; dp_in = 4'h0;
         end else begin
            load = 1'b0;
         end
         tick();
      end
   endtask

   task automatic test_lz;
      logic [11:0] e0, e1;
      do_reset();
      while (cyc <= 63) begin
         e0 = (cyc >= 32) ? exp_out(16'h0040, 4'h0, cyc, 1'b0) : exp_out(16'h0000, 4'h0, cyc, 1'b0);
         e1 = (cyc >= 32) ? exp_out(16'h0040, 4'h0, cyc, 1'b1) : exp_out(16'h0000, 4'h0, cyc, 1'b1);
         n_tests++;
         if ({sa0, led0} !== e0 || {sa1, led1} !== e1) begin
            n_fail++;
            $display("FAIL lz c=%0d got sa0=%b led0=%h sa1=%b led1=%h exp sa0=%b led0=%h sa1=%b led1=%h",
                     cyc, sa0, led0, sa1, led1, e0[11:8], e0[7:0], e1[11:8], e1[7:0]);
         end
         if (cyc == 34 || cyc == 42 || cyc == 50 || cyc == 58) begin
            n_tests++;
            if ({sa1, led1} !== ((cyc == 34) ? 12'h13F : (cyc == 42) ? 12'h266 :
                                 (cyc == 50) ? 12'h400 : 12'h800)) begin
               n_fail++;
               $display("FAIL lz_digit c=%0d got sa=%b led=%h", cyc, sa1, led1);
            end
         end
         if (cyc == 2) begin
            load = 1'b1; data_in = 16'h0040; dp_in = 4'h0;
         end else begin
            load = 1'b0;
         end
         tick();
      end
      load = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [11:0] e;
      do_reset();
      while (cyc <= 20) begin
         e = exp_out(16'h0000, 4'h0, cyc, 1'b0);
         n_tests++;
         if ({sa0, led0} !== e) begin
            n_fail++;
            $display("FAIL rst_mid_pre c=%0d got sa=%b led=%h exp sa=%b led=%h",
                     cyc, sa0, led0, e[11:8], e[7:0]);
         end
         if (cyc == 18) begin
            load = 1'b1; data_in = 16'hABCD; dp_in = 4'hF;
         end else begin
            load = 1'b0;
         end
         if (cyc == 20) rst_n = 1'b0;
         tick();
      end
      n_tests++;
      if ({sa0, led0, fu0} !== 13'h0000) begin
         n_fail++;
         $display("FAIL rst_mid_now got sa=%b led=%h fu=%b exp sa=0000 led=00 fu=0", sa0, led0, fu0);
      end
      rst_n = 1'b1;
      cyc   = 0;
      while (cyc <= 70) begin
         e = exp_out(16'h0000, 4'h0, cyc, 1'b0);
         n_tests++;
         if ({sa0, led0} !== e || fu0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_post c=%0d got sa=%b led=%h fu=%b exp sa=%b led=%h fu=0",
                     cyc, sa0, led0, fu0, e[11:8], e[7:0]);
         end
         tick();
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      load    = 1'b0;
      data_in = 16'h0000;
      dp_in   = 4'h0;
      test_reset();
      test_scan();
      test_load();
      test_two_loads();
      test_boundary_load();
      test_lz();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
